// File: rtl/card_arbiter.sv
// card_arbiter: round-robin owner of card_driver for two clients. Issues the
// sector command for the winner, then steers its byte handshakes to the driver.
module card_arbiter #(
  parameter int SECTOR_BYTES = 512
) (
  input  logic        CLOCK50,
  input  logic        RESET,

  input  logic        C0_REQ,
  input  logic        C0_WE,
  input  logic [31:0] C0_ADDR,
  output logic        C0_GNT,
  output logic        C0_DONE,
  input  logic        C0_WD_STB,
  input  logic [7:0]  C0_WD_DATA,
  output logic        C0_WD_ACK,
  output logic        C0_RES_STB,
  output logic [7:0]  C0_RES_DATA,
  input  logic        C0_RES_ACK,

  input  logic        C1_REQ,
  input  logic        C1_WE,
  input  logic [31:0] C1_ADDR,
  output logic        C1_GNT,
  output logic        C1_DONE,
  input  logic        C1_WD_STB,
  input  logic [7:0]  C1_WD_DATA,
  output logic        C1_WD_ACK,
  output logic        C1_RES_STB,
  output logic [7:0]  C1_RES_DATA,
  input  logic        C1_RES_ACK,

  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  input  logic        WR_ACK,
  output logic        WD_STB,
  output logic [7:0]  WD_DATA,
  input  logic        WD_ACK,
  output logic        RD_STB,
  output logic [31:0] RD_ADDR,
  input  logic        RD_ACK,
  input  logic        RES_STB,
  input  logic [7:0]  RES_DATA,
  output logic        RES_ACK
);

  // state     | meaning
  // S_IDLE    | no owner; arbitrate among requests
  // S_CMD_WR  | write command to driver, wait WR_ACK
  // S_DATA_WR | route write bytes from owner to driver
  // S_CMD_RD  | read command to driver, wait RD_ACK
  // S_DATA_RD | route result bytes from driver to owner
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD_WR  = 3'd1,
    S_DATA_WR = 3'd2,
    S_CMD_RD  = 3'd3,
    S_DATA_RD = 3'd4
  } state_t;

  localparam logic [10:0] LAST_COUNT = 11'(SECTOR_BYTES);

  state_t      state_q, state_d;
  logic        sel_q;
  logic        last_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [31:0] addr_q;
  logic [9:0]  cnt_q;

  logic        req_any;
  logic        winner;
  logic        win_we;
  logic [31:0] win_addr;
  logic        cl_wd_stb;
  logic [7:0]  cl_wd_data;
  logic        cl_res_ack;
  logic        wr_xfer;
  logic        rd_xfer;
  logic        xfer;
  logic        last_byte;
  logic        cmd_done;

  // On a tie the client that was not served last wins.
  assign req_any  = C0_REQ | C1_REQ;
  assign winner   = (C0_REQ & C1_REQ) ? ~last_q : C1_REQ;
  assign win_we   = winner ? C1_WE : C0_WE;
  assign win_addr = winner ? C1_ADDR : C0_ADDR;

  assign cl_wd_stb  = sel_q ? C1_WD_STB  : C0_WD_STB;
  assign cl_wd_data = sel_q ? C1_WD_DATA : C0_WD_DATA;
  assign cl_res_ack = sel_q ? C1_RES_ACK : C0_RES_ACK;

  assign wr_xfer   = (state_q == S_DATA_WR) & cl_wd_stb & WD_ACK;
  assign rd_xfer   = (state_q == S_DATA_RD) & RES_STB & cl_res_ack;
  assign xfer      = wr_xfer | rd_xfer;
  assign last_byte = xfer & (({1'b0, cnt_q} + 11'd1) == LAST_COUNT);
  assign cmd_done  = ((state_q == S_CMD_WR) & WR_ACK) | ((state_q == S_CMD_RD) & RD_ACK);

  assign C0_GNT  = gnt_q[0];
  assign C1_GNT  = gnt_q[1];
  assign C0_DONE = done_q[0];
  assign C1_DONE = done_q[1];

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_any) state_d = win_we ? S_CMD_WR : S_CMD_RD;
      S_CMD_WR:  if (WR_ACK) state_d = S_DATA_WR;
      S_DATA_WR: if (last_byte) state_d = S_IDLE;
      S_CMD_RD:  if (RD_ACK) state_d = S_DATA_RD;
      S_DATA_RD: if (last_byte) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Owner, latched command and byte count; request inputs are only looked at in IDLE.
  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      sel_q  <= 1'b0;
      last_q <= 1'b1;
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      addr_q <= 32'd0;
      cnt_q  <= 10'd0;
    end else begin
      done_q <= 2'b00;
      if ((state_q == S_IDLE) && req_any) begin
        sel_q  <= winner;
        gnt_q  <= winner ? 2'b10 : 2'b01;
        addr_q <= win_addr;
      end
      if (cmd_done || last_byte) begin
        cnt_q <= 10'd0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 10'd1;
      end
      if (last_byte) begin
        gnt_q  <= 2'b00;
        done_q <= sel_q ? 2'b10 : 2'b01;
        last_q <= sel_q;
      end
    end
  end

  always_comb begin
    WR_STB      = 1'b0;
    WR_ADDR     = 32'd0;
    RD_STB      = 1'b0;
    RD_ADDR     = 32'd0;
    WD_STB      = 1'b0;
    WD_DATA     = 8'd0;
    RES_ACK     = 1'b0;
    C0_WD_ACK   = 1'b0;
    C1_WD_ACK   = 1'b0;
    C0_RES_STB  = 1'b0;
    C1_RES_STB  = 1'b0;
    C0_RES_DATA = 8'd0;
    C1_RES_DATA = 8'd0;
    case (state_q)
      S_CMD_WR: begin
        WR_STB  = 1'b1;
        WR_ADDR = addr_q;
      end
      S_CMD_RD: begin
        RD_STB  = 1'b1;
        RD_ADDR = addr_q;
      end
      S_DATA_WR: begin
        WD_STB  = cl_wd_stb;
        WD_DATA = cl_wd_data;
        if (sel_q) C1_WD_ACK = WD_ACK;
        else       C0_WD_ACK = WD_ACK;
      end
      S_DATA_RD: begin
        RES_ACK = cl_res_ack;
        if (sel_q) begin
          C1_RES_STB  = RES_STB;
          C1_RES_DATA = RES_DATA;
        end else begin
          C0_RES_STB  = RES_STB;
          C0_RES_DATA = RES_DATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_card_arbiter.sv
// Bench for card_arbiter: directed transactions push expected events into a
// queue; a negedge monitor pops and compares each event the DUT presents.
module tb_card_arbiter;

  localparam int NB = 4;
  localparam logic [2:0] K_CMDW = 3'd1, K_CMDR = 3'd2, K_WD = 3'd3, K_RES = 3'd4, K_DONE = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  who;
    logic [31:0] val;
  } ev_t;

  logic        CLOCK50 = 1'b0;
  logic        RESET;
  logic        C0_REQ, C0_WE, C0_WD_STB, C0_RES_ACK;
  logic [31:0] C0_ADDR;
  logic [7:0]  C0_WD_DATA;
  logic        C1_REQ, C1_WE, C1_WD_STB, C1_RES_ACK;
  logic [31:0] C1_ADDR;
  logic [7:0]  C1_WD_DATA;
  logic        C0_GNT, C0_DONE, C0_WD_ACK, C0_RES_STB;
  logic [7:0]  C0_RES_DATA;
  logic        C1_GNT, C1_DONE, C1_WD_ACK, C1_RES_STB;
  logic [7:0]  C1_RES_DATA;
  logic        WR_STB, WD_STB, RD_STB, RES_ACK;
  logic [31:0] WR_ADDR, RD_ADDR;
  logic [7:0]  WD_DATA;
  logic        WR_ACK, WD_ACK, RD_ACK, RES_STB;
  logic [7:0]  RES_DATA;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  card_arbiter #(.SECTOR_BYTES(NB)) dut (
    .CLOCK50(CLOCK50), .RESET(RESET),
    .C0_REQ(C0_REQ), .C0_WE(C0_WE), .C0_ADDR(C0_ADDR), .C0_GNT(C0_GNT), .C0_DONE(C0_DONE),
    .C0_WD_STB(C0_WD_STB), .C0_WD_DATA(C0_WD_DATA), .C0_WD_ACK(C0_WD_ACK),
    .C0_RES_STB(C0_RES_STB), .C0_RES_DATA(C0_RES_DATA), .C0_RES_ACK(C0_RES_ACK),
    .C1_REQ(C1_REQ), .C1_WE(C1_WE), .C1_ADDR(C1_ADDR), .C1_GNT(C1_GNT), .C1_DONE(C1_DONE),
    .C1_WD_STB(C1_WD_STB), .C1_WD_DATA(C1_WD_DATA), .C1_WD_ACK(C1_WD_ACK),
    .C1_RES_STB(C1_RES_STB), .C1_RES_DATA(C1_RES_DATA), .C1_RES_ACK(C1_RES_ACK),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_ACK(WR_ACK),
    .WD_STB(WD_STB), .WD_DATA(WD_DATA), .WD_ACK(WD_ACK),
    .RD_STB(RD_STB), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK),
    .RES_STB(RES_STB), .RES_DATA(RES_DATA), .RES_ACK(RES_ACK)
  );

  always #5 CLOCK50 = ~CLOCK50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: at most one event per cycle; the 'who' field is the one-hot set of
  // clients that saw the grant/ack/strobe, so misrouting shows up as a mismatch.
  ev_t mon_ev;
  ev_t mon_exp;
  logic mon_got;
  always @(negedge CLOCK50) begin
    if (RESET) begin
      mon_got = 1'b1;
      if (WR_STB && WR_ACK)
        mon_ev = '{K_CMDW, {C1_GNT, C0_GNT}, WR_ADDR};
      else if (RD_STB && RD_ACK)
        mon_ev = '{K_CMDR, {C1_GNT, C0_GNT}, RD_ADDR};
      else if (WD_STB && WD_ACK)
        mon_ev = '{K_WD, {C1_WD_ACK, C0_WD_ACK}, {24'd0, WD_DATA}};
      else if (RES_STB && RES_ACK)
        mon_ev = '{K_RES, {C1_RES_STB, C0_RES_STB}, {24'd0, C0_RES_DATA | C1_RES_DATA}};
      else if (C0_DONE || C1_DONE)
        mon_ev = '{K_DONE, {C1_DONE, C0_DONE}, {30'd0, C1_GNT, C0_GNT}};
      else
        mon_got = 1'b0;
      if (mon_got) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got %0h expected none", mon_ev);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_ev !== mon_exp) begin
            n_err++;
            $display("FAIL event: got kind=%0d who=%b val=%0h expected kind=%0d who=%b val=%0h",
                     mon_ev.kind, mon_ev.who, mon_ev.val, mon_exp.kind, mon_exp.who, mon_exp.val);
          end
        end
      end
    end
  end

  task automatic set_req(input int c, input logic we, input logic [31:0] addr);
    if (c == 0) begin C0_REQ = 1'b1; C0_WE = we; C0_ADDR = addr; end
    else        begin C1_REQ = 1'b1; C1_WE = we; C1_ADDR = addr; end
  endtask

  task automatic set_wd(input int c, input logic stb, input logic [7:0] d);
    if (c == 0) begin C0_WD_STB = stb; C0_WD_DATA = d; end
    else        begin C1_WD_STB = stb; C1_WD_DATA = d; end
  endtask

  task automatic set_res_ack(input int c, input logic a);
    if (c == 0) C0_RES_ACK = a;
    else        C1_RES_ACK = a;
  endtask

  // One full transaction for client c; bytes[31:24] is the first byte.
  task automatic txn(input int c, input logic we, input logic [31:0] addr, input logic [31:0] bytes,
                     input int stall, input logic [1:0] drop, input logic poke_addr);
    ev_t e;
    int waitc;
    logic [7:0] bv;
    logic [1:0] oh;
    oh = (c == 0) ? 2'b01 : 2'b10;
    e = '{we ? K_CMDW : K_CMDR, oh, addr};
    exp_q.push_back(e);
    for (int i = 0; i < NB; i++) begin
      e = '{we ? K_WD : K_RES, oh, {24'd0, bytes[31-8*i -: 8]}};
      exp_q.push_back(e);
    end
    e = '{K_DONE, oh, 32'd0};
    exp_q.push_back(e);

    set_req(c, we, addr);
    waitc = 0;
    do begin
      @(posedge CLOCK50); #1;
      waitc++;
    end while (!(C0_GNT || C1_GNT) && waitc < 20);
    chk("grant_latency", waitc, 1);
    if (drop[0]) C0_REQ = 1'b0;
    if (drop[1]) C1_REQ = 1'b0;
    if (poke_addr) begin
      if (c == 0) C0_ADDR = 32'hDEAD_BEEF;
      else        C1_ADDR = 32'hDEAD_BEEF;
    end

    if (we) WR_ACK = 1'b1;
    else    RD_ACK = 1'b1;
    @(posedge CLOCK50); #1;
    WR_ACK = 1'b0;
    RD_ACK = 1'b0;

    for (int i = 0; i < NB; i++) begin
      bv = bytes[31-8*i -: 8];
      if (we) begin
        set_wd(c, 1'b1, bv);
        WD_ACK = 1'b0;
        repeat (stall) begin @(posedge CLOCK50); #1; end
        WD_ACK = 1'b1;
        @(posedge CLOCK50); #1;
        WD_ACK = 1'b0;
      end else begin
        RES_STB = 1'b1;
        RES_DATA = bv;
        set_res_ack(c, 1'b0);
        repeat (stall) begin
          @(posedge CLOCK50); #1;
          chk("res_stb_held", (c == 0) ? {C0_RES_STB, C0_RES_DATA} : {C1_RES_STB, C1_RES_DATA}, {1'b1, bv});
        end
        set_res_ack(c, 1'b1);
        @(posedge CLOCK50); #1;
        set_res_ack(c, 1'b0);
      end
    end
    set_wd(c, 1'b0, 8'd0);
    RES_STB = 1'b0;
    RES_DATA = 8'd0;
  endtask

  function automatic logic [127:0] all_outs();
    return {28'd0,
            C0_GNT, C0_DONE, C0_WD_ACK, C0_RES_STB, C0_RES_DATA,
            C1_GNT, C1_DONE, C1_WD_ACK, C1_RES_STB, C1_RES_DATA,
            WR_STB, WR_ADDR, WD_STB, WD_DATA, RD_STB, RD_ADDR, RES_ACK};
  endfunction

  initial begin
    RESET = 1'b0;
    C0_REQ = 0; C0_WE = 0; C0_ADDR = 0; C0_WD_STB = 0; C0_WD_DATA = 0; C0_RES_ACK = 0;
    C1_REQ = 0; C1_WE = 0; C1_ADDR = 0; C1_WD_STB = 0; C1_WD_DATA = 0; C1_RES_ACK = 0;
    WR_ACK = 0; WD_ACK = 0; RD_ACK = 0; RES_STB = 0; RES_DATA = 0;

    // Request held through reset must not produce a grant.
    set_req(0, 1'b1, 32'h10);
    repeat (3) begin
      @(negedge CLOCK50);
      chk("reset_hold", {C0_GNT, C1_GNT, WR_STB, RD_STB, C0_DONE, C1_DONE}, 6'd0);
    end
    @(posedge CLOCK50); #1;
    RESET = 1'b1;

    txn(0, 1'b1, 32'h0000_0010, 32'hABCD_EF01, 1, 2'b01, 1'b0);
    // REQ dropped and ADDR changed after grant: original address must be used.
    txn(0, 1'b1, 32'h0000_0030, 32'h0A0B_0C0D, 0, 2'b01, 1'b1);

    // Reset in the middle of a write, on the third byte.
    exp_q.push_back('{K_CMDW, 2'b01, 32'h40});
    exp_q.push_back('{K_WD, 2'b01, 32'h11});
    exp_q.push_back('{K_WD, 2'b01, 32'h22});
    set_req(0, 1'b1, 32'h40);
    @(posedge CLOCK50); #1;
    C0_REQ = 1'b0;
    WR_ACK = 1'b1;
    @(posedge CLOCK50); #1;
    WR_ACK = 1'b0;
    set_wd(0, 1'b1, 8'h11); WD_ACK = 1'b1;
    @(posedge CLOCK50); #1;
    set_wd(0, 1'b1, 8'h22);
    @(posedge CLOCK50); #1;
    set_wd(0, 1'b1, 8'h33);
    RESET = 1'b0;
    #1;
    chk("reset_mid_outputs", all_outs(), 128'd0);
    set_wd(0, 1'b0, 8'd0);
    WD_ACK = 1'b0;
    @(posedge CLOCK50); #1;
    RESET = 1'b1;

    // Read restarts at CMD after reset; client accepts each byte after 2 stall cycles.
    txn(1, 1'b0, 32'h0000_0020, 32'h5556_5758, 2, 2'b10, 1'b0);

    // Round-robin with both requesting: C0, C1, C0, C1.
    set_req(0, 1'b1, 32'h100);
    set_req(1, 1'b0, 32'h200);
    txn(0, 1'b1, 32'h0000_0100, 32'h1122_3344, 0, 2'b00, 1'b0);
    txn(1, 1'b0, 32'h0000_0200, 32'hA1A2_A3A4, 1, 2'b00, 1'b0);
    txn(0, 1'b0, 32'h0000_0300, 32'hB1B2_B3B4, 0, 2'b00, 1'b0);
    txn(1, 1'b1, 32'h0000_0400, 32'hC1C2_C3C4, 0, 2'b11, 1'b0);

    repeat (3) @(posedge CLOCK50);
    #1;
    chk("idle_after_all", {C0_GNT, C1_GNT, WR_STB, RD_STB}, 4'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
